// File: rtl/mem_arbiter.sv
// Two-requester (VGA, CPU) single-port memory arbiter: IDLE/ISSUE/RESP, one access per two cycles.
// Optional CPU starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_adr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [15:0] cpu_rdata,
   input  logic        vga_req,
   input  logic [15:0] vga_adr,
   output logic        vga_gnt,
   output logic        vga_rvalid,
   output logic [15:0] vga_rdata,
   output logic [15:0] mem_adr,
   output logic [15:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t r_state;
   logic   r_owner_vga;
   logic   r_is_read;
   logic   w_any_req;
   logic   w_arb;
   logic   w_pick_cpu;

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_range
      $error("mem_arbiter: STARVE_MAX must be in 1..15");
   end

   assign w_any_req = cpu_req | vga_req;
   assign w_arb     = (r_state == IDLE) || (r_state == RESP);

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] r_starve;

   // CPU wins over a pending VGA request once VGA has taken STARVE_MAX grants in a row
   assign w_pick_cpu = cpu_req && (!vga_req || (r_starve >= 4'(STARVE_MAX)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve <= '0;
      end else if (!cpu_req) begin
         r_starve <= '0;
      end else if (w_arb && w_any_req) begin
         if (w_pick_cpu)
            r_starve <= '0;
         else if (r_starve != 4'hF)
            r_starve <= r_starve + 4'd1;
      end
   end
`else
   assign w_pick_cpu = cpu_req && !vga_req;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_owner_vga <= 1'b0;
         r_is_read   <= 1'b0;
         cpu_gnt     <= 1'b0;
         cpu_rvalid  <= 1'b0;
         cpu_rdata   <= '0;
         vga_gnt     <= 1'b0;
         vga_rvalid  <= 1'b0;
         vga_rdata   <= '0;
         mem_adr     <= '0;
         mem_wdata   <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
      end else begin
         cpu_gnt    <= 1'b0;
         vga_gnt    <= 1'b0;
         cpu_rvalid <= 1'b0;
         vga_rvalid <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         case (r_state)
            IDLE, RESP: begin
               // Read completion and the next arbitration share the RESP edge
               if (r_state == RESP && r_is_read) begin
                  if (r_owner_vga) begin
                     vga_rdata  <= mem_rdata;
                     vga_rvalid <= 1'b1;
                  end else begin
                     cpu_rdata  <= mem_rdata;
                     cpu_rvalid <= 1'b1;
                  end
               end
               if (w_any_req) begin
                  r_state <= ISSUE;
                  if (w_pick_cpu) begin
                     r_owner_vga <= 1'b0;
                     r_is_read   <= !cpu_we;
                     mem_adr     <= cpu_adr;
                     mem_wdata   <= cpu_wdata;
                     mem_read    <= !cpu_we;
                     mem_write   <= cpu_we;
                     cpu_gnt     <= 1'b1;
                  end else begin
                     r_owner_vga <= 1'b1;
                     r_is_read   <= 1'b1;
                     mem_adr     <= vga_adr;
                     mem_wdata   <= '0;
                     mem_read    <= 1'b1;
                     vga_gnt     <= 1'b1;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            ISSUE:   r_state <= RESP;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected read data queued at request time, checked on rvalid.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_adr, cpu_wdata;
   logic        cpu_gnt, cpu_rvalid;
   logic [15:0] cpu_rdata;
   logic        vga_req;
   logic [15:0] vga_adr;
   logic        vga_gnt, vga_rvalid;
   logic [15:0] vga_rdata;
   logic [15:0] mem_adr, mem_wdata;
   logic        mem_read, mem_write;
   logic [15:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;
   logic [15:0] cpu_q[$];
   logic [15:0] vga_q[$];
   logic [15:0] mem_arr [logic [15:0]];

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .vga_req(vga_req), .vga_adr(vga_adr),
      .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [15:0] pat(input logic [15:0] a);
      return a ^ 16'hA5C3;
   endfunction

   // Memory model: unwritten words hold pat(addr); read data appears the cycle after mem_read
   always @(posedge clk) begin
      if (mem_write) mem_arr[mem_adr] = mem_wdata;
      if (mem_read) mem_rdata <= mem_arr.exists(mem_adr) ? mem_arr[mem_adr] : pat(mem_adr);
   end

   task automatic scoreboard_mon();
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (cpu_rvalid) begin
            checks++;
            if (cpu_q.size() == 0) begin
               errors++;
               $display("FAIL cpu_rvalid_unexpected rdata=%h", cpu_rdata);
            end else begin
               e = cpu_q.pop_front();
               if (cpu_rdata !== e) begin
                  errors++;
                  $display("FAIL cpu_rdata got %h exp %h", cpu_rdata, e);
               end
            end
         end
         if (vga_rvalid) begin
            checks++;
            if (vga_q.size() == 0) begin
               errors++;
               $display("FAIL vga_rvalid_unexpected rdata=%h", vga_rdata);
            end else begin
               e = vga_q.pop_front();
               if (vga_rdata !== e) begin
                  errors++;
                  $display("FAIL vga_rdata got %h exp %h", vga_rdata, e);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
      vga_req = 1'b0; vga_adr = '0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid, mem_read, mem_write} !== 6'b0) begin
         errors++;
         $display("FAIL reset_pulses got %b exp 000000",
                  {cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid, mem_read, mem_write});
      end
      checks++;
      if ({mem_adr, mem_wdata, cpu_rdata, vga_rdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_data got %h exp 0", {mem_adr, mem_wdata, cpu_rdata, vga_rdata});
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({cpu_gnt, vga_gnt, mem_read, mem_write} !== 4'b0) begin
         errors++;
         $display("FAIL idle_no_req got %b exp 0000", {cpu_gnt, vga_gnt, mem_read, mem_write});
      end
   endtask

   task automatic test_cpu_write();
      logic rv, extra;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0010; cpu_wdata = 16'hBEEF;
      @(negedge clk);
      checks++;
      if ({cpu_gnt, vga_gnt, mem_write, mem_read} !== 4'b1010) begin
         errors++;
         $display("FAIL wr_strobes got %b exp 1010", {cpu_gnt, vga_gnt, mem_write, mem_read});
      end
      checks++;
      if ({mem_adr, mem_wdata} !== {16'h0010, 16'hBEEF}) begin
         errors++;
         $display("FAIL wr_bus got %h/%h exp 0010/beef", mem_adr, mem_wdata);
      end
      cpu_req = 1'b0; cpu_we = 1'b0;
      rv = 1'b0; extra = 1'b0;
      repeat (4) begin
         @(negedge clk);
         rv    |= cpu_rvalid;
         extra |= cpu_gnt | mem_write;
      end
      checks++;
      if (rv !== 1'b0) begin
         errors++;
         $display("FAIL wr_no_rvalid got %b exp 0", rv);
      end
      checks++;
      if (extra !== 1'b0) begin
         errors++;
         $display("FAIL wr_single_cycle got %b exp 0", extra);
      end
   endtask

   task automatic test_cpu_read();
      int lat;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0010;
      cpu_q.push_back(16'hBEEF);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (cpu_gnt) begin
            checks++;
            if ({mem_read, mem_write, mem_adr} !== {2'b10, 16'h0010}) begin
               errors++;
               $display("FAIL rd_issue got %b%b/%h exp 10/0010", mem_read, mem_write, mem_adr);
            end
            cpu_req = 1'b0;
         end
         if (cpu_rvalid) begin
            lat = k;
            break;
         end
      end
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL rd_latency got %0d exp 3", lat);
      end
   endtask

   task automatic test_priority();
      int vg, cg;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0010;
      vga_req = 1'b1; vga_adr = 16'h0200;
      cpu_q.push_back(16'hBEEF);
      vga_q.push_back(pat(16'h0200));
      vg = 0; cg = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (vga_gnt && vg == 0) begin vg = k; vga_req = 1'b0; end
         if (cpu_gnt && cg == 0) begin cg = k; cpu_req = 1'b0; end
      end
      checks++;
      if (vg !== 1 || cg !== 3) begin
         errors++;
         $display("FAIL prio_order got vga@%0d cpu@%0d exp vga@1 cpu@3", vg, cg);
      end
      checks++;
      if (cpu_q.size() + vga_q.size() !== 0) begin
         errors++;
         $display("FAIL prio_drain got %0d pending exp 0", cpu_q.size() + vga_q.size());
      end
   endtask

   task automatic test_starvation();
      int nv, cg, nv_at_cg;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0300; cpu_wdata = 16'h1234;
      vga_req = 1'b1; vga_adr = 16'h0400;
      nv = 0; cg = 0; nv_at_cg = -1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (vga_gnt) begin
            nv++;
            vga_q.push_back(pat(16'h0400));
         end
         if (cpu_gnt && cg == 0) begin
            cg = k; nv_at_cg = nv; cpu_req = 1'b0; cpu_we = 1'b0;
         end
      end
      vga_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      repeat (6) @(negedge clk);
`ifdef ARB_STARVE_GUARD_EN
      checks++;
      if (cg !== 9 || nv_at_cg !== 4) begin
         errors++;
         $display("FAIL starve_guard got cpu@%0d after %0d vga exp cpu@9 after 4", cg, nv_at_cg);
      end
      checks++;
      if (nv !== 11) begin
         errors++;
         $display("FAIL starve_vga_count got %0d exp 11", nv);
      end
`else
      checks++;
      if (cg !== 0) begin
         errors++;
         $display("FAIL strict_prio got cpu_gnt@%0d exp never", cg);
      end
      checks++;
      if (nv !== 12) begin
         errors++;
         $display("FAIL strict_vga_count got %0d exp 12", nv);
      end
`endif
      checks++;
      if (vga_q.size() !== 0) begin
         errors++;
         $display("FAIL starve_drain got %0d pending exp 0", vga_q.size());
      end
   endtask

   task automatic test_reset_midaccess();
      logic act;
      @(negedge clk);
      vga_req = 1'b1; vga_adr = 16'h0500;
      @(negedge clk);
      checks++;
      if (vga_gnt !== 1'b1) begin
         errors++;
         $display("FAIL mid_gnt got %b exp 1", vga_gnt);
      end
      vga_req = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({mem_adr, mem_wdata, cpu_rdata, vga_rdata} !== 64'h0 ||
          {cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid, mem_read, mem_write} !== 6'b0) begin
         errors++;
         $display("FAIL mid_async_reset got adr=%h vrd=%h crd=%h exp 0",
                  mem_adr, vga_rdata, cpu_rdata);
      end
      @(negedge clk);
      rst = 1'b1;
      act = 1'b0;
      repeat (4) begin
         @(negedge clk);
         act |= vga_rvalid | cpu_rvalid | vga_gnt | cpu_gnt | mem_read | mem_write;
      end
      checks++;
      if (act !== 1'b0) begin
         errors++;
         $display("FAIL mid_discard got activity=%b exp 0", act);
      end
   endtask

   task automatic test_back_to_back();
      int n, rvc;
      int gcyc[4];
      @(negedge clk);
      vga_req = 1'b1; vga_adr = 16'h0100;
      for (int i = 0; i < 4; i++) vga_q.push_back(pat(16'h0100 + 16'(i)));
      n = 0; rvc = 0;
      for (int i = 0; i < 4; i++) gcyc[i] = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (vga_rvalid) rvc++;
         if (vga_gnt && n < 4) begin
            gcyc[n] = k;
            n++;
            if (n == 4) vga_req = 1'b0;
            else vga_adr = 16'h0100 + 16'(n);
         end
      end
      checks++;
      if (gcyc[0] !== 1 || gcyc[1] !== 3 || gcyc[2] !== 5 || gcyc[3] !== 7) begin
         errors++;
         $display("FAIL b2b_gnt_cycles got %0d,%0d,%0d,%0d exp 1,3,5,7",
                  gcyc[0], gcyc[1], gcyc[2], gcyc[3]);
      end
      checks++;
      if (rvc !== 4 || vga_q.size() !== 0) begin
         errors++;
         $display("FAIL b2b_rvalid got %0d pulses %0d pending exp 4/0", rvc, vga_q.size());
      end
   endtask

   initial begin
      fork
         scoreboard_mon();
      join_none
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_priority();
      test_starvation();
      test_reset_midaccess();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive VGA grants while cpu_req is pending (range 1..15).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_req  input  1  CPU datapath access request, held until cpu_gnt.
REQ-005 SHALL have port cpu_we  input  1  CPU access type: 1 = write, 0 = read.
REQ-006 SHALL have port cpu_adr  input  16  CPU word address.
REQ-007 SHALL have port cpu_wdata  input  16  CPU write data.
REQ-008 SHALL have port cpu_gnt  output  1  one-cycle pulse: CPU access issued.
REQ-009 SHALL have port cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid.
REQ-010 SHALL have port cpu_rdata  output  16  CPU read data.
REQ-011 SHALL have port vga_req  input  1  VGA read request, held until vga_gnt.
REQ-012 SHALL have port vga_adr  input  16  VGA word address.
REQ-013 SHALL have port vga_gnt  output  1  one-cycle pulse: VGA read issued.
REQ-014 SHALL have port vga_rvalid  output  1  one-cycle pulse: vga_rdata valid.
REQ-015 SHALL have port vga_rdata  output  16  VGA read data.
REQ-016 SHALL have port mem_adr  output  16  shared memory address.
REQ-017 SHALL have port mem_wdata  output  16  shared memory write data.
REQ-018 SHALL have ports mem_read and mem_write  output  1 each  memory strobes.
REQ-019 SHALL have port mem_rdata  input  16  memory read data, valid the cycle after the mem_read cycle.

Function
REQ-020 SHALL implement states IDLE, ISSUE, RESP; IDLE->ISSUE when any req is high, ISSUE->RESP unconditionally, RESP->ISSUE when any req is high, otherwise RESP->IDLE.
REQ-021 SHALL arbitrate in IDLE and RESP, registering the winner's adr/wdata/type into mem_* and the owner flag at the transition to ISSUE.
REQ-022 SHALL assert mem_read or mem_write, plus the winner's gnt, for exactly the single ISSUE cycle; all other cycles strobes = 0.
REQ-023 SHALL register mem_rdata at the end of RESP for reads and pulse the owner's rvalid in the following cycle with the data on its rdata; writes produce no rvalid.
REQ-024 SHALL hold cpu_rdata/vga_rdata stable until the next read completion for that requester.
REQ-025 SHALL give VGA priority over CPU when both request in the same arbitration cycle.
REQ-026 SHALL sustain one access per 2 cycles under continuous requests; read latency = 3 cycles from the arbitration-cycle edge to rvalid.
REQ-027 SHALL sample req only in arbitration cycles; req held high in RESP after gnt counts as a new request.
REQ-028 SHALL treat vga_req with cpu_we irrelevant (VGA always reads).

Reset
REQ-029 SHALL, on rst low, immediately force state IDLE, all gnt/rvalid/strobes 0, mem_adr/mem_wdata/rdata outputs 0, and the starvation counter 0, including mid-access; an in-flight read is discarded without rvalid.
REQ-030 SHALL begin arbitration on the first rising clk edge after rst deasserts.

Configuration
REQ-031 SHALL, with ARB_STARVE_GUARD_EN defined, count consecutive VGA grants while cpu_req is high, and after STARVE_MAX such grants grant CPU at the next arbitration regardless of vga_req; the counter clears on a CPU grant or when cpu_req is low.
REQ-032 SHALL, without ARB_STARVE_GUARD_EN, use strict VGA priority with no counter logic present.

Verification
REQ-033 Single CPU write adr=0x0010 wdata=0xBEEF -> one cycle mem_write=1, mem_adr=0x0010, mem_wdata=0xBEEF, cpu_gnt pulse, no cpu_rvalid.
REQ-034 CPU read adr=0x0010 with mem_rdata=0xBEEF -> cpu_rvalid pulse 3 cycles after request, cpu_rdata=0xBEEF.
REQ-035 cpu_req and vga_req asserted in the same cycle -> vga_gnt first, cpu_gnt 2 cycles later.
REQ-036 vga_req held high continuously plus cpu_req high, guard enabled, STARVE_MAX=4 -> 4 vga_gnt pulses then 1 cpu_gnt; guard disabled -> cpu_gnt never asserted.
REQ-037 rst driven low during RESP of a VGA read -> outputs 0 asynchronously, no vga_rvalid, state IDLE after release.
REQ-038 Back-to-back VGA reads adr 0x0100..0x0103 -> vga_gnt every 2 cycles, four vga_rvalid pulses with data in order.
